// File: rtl/mfp_ahb_uart_tx_pkg.sv
// Shared constants for the AHB-Lite UART transmitter: register offsets,
// STATUS bit positions, reset baud divisor and transmitter state codes.
package mfp_ahb_uart_tx_pkg;

  // Register offsets as seen on HADDR[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  // STATUS bit positions; the entry count occupies [8:4]
  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_CNT_LSB   = 4;
  localparam int ST_CNT_MSB   = 8;

  // 50 MHz / 115200 baud
  localparam logic [15:0] UART_DEFAULT_DIV = 16'd434;

  // Transmitter states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // A divisor of zero would never finish a bit, so it behaves as one
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/mfp_ahb_uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. The caller guarantees it
// never pushes into a full FIFO (unless popping the same cycle) and never
// pops an empty one. Read data is the current head entry.
module mfp_uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [4:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [4:0]    count_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {4'd0, push_i} - {4'd0, pop_i};
    end
  end

  // Storage array; contents need no reset because occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 5'(DEPTH));
  assign empty_o = (count_q == 5'd0);
  assign count_o = count_q;

endmodule

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite UART transmitter slave: TXDATA/STATUS/DIV registers, a small
// byte FIFO and an 8N1 serialiser with a per-frame latched baud divisor.
module mfp_ahb_uart_tx
  import mfp_ahb_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        UART_TX
);

  // Address-phase capture
  logic        dsel_q;
  logic        dwr_q;
  logic [1:0]  daddr_q;

  // Registers
  logic [15:0] div_q;
  logic        ovf_q;

  // Serialiser
  logic [1:0]  state_q,   state_d;
  logic [15:0] timer_q,   timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q,   shift_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic        tx_q,      tx_d;

  // FIFO interface
  logic        fifo_push_s;
  logic        fifo_pop_s;
  logic [7:0]  fifo_rdata_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [4:0]  fifo_count_s;

  logic        txdata_wr_s;
  logic        status_wr_s;
  logic        div_wr_s;
  logic        ovf_set_s;
  logic        bit_done_s;
  logic [31:0] status_s;

  logic        unused_s;
  assign unused_s = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

  // Latch the address phase so the data phase can act on it
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q  <= 1'b0;
      dwr_q   <= 1'b0;
      daddr_q <= 2'd0;
    end else begin
      dsel_q  <= HSEL & HTRANS[1];
      dwr_q   <= HWRITE;
      daddr_q <= HADDR[3:2];
    end
  end

  assign txdata_wr_s = dsel_q & dwr_q & (daddr_q == REG_TXDATA);
  assign status_wr_s = dsel_q & dwr_q & (daddr_q == REG_STATUS);
  assign div_wr_s    = dsel_q & dwr_q & (daddr_q == REG_DIV);

  // A full FIFO still accepts a byte when the serialiser drains one this cycle
  assign fifo_push_s = txdata_wr_s & (~fifo_full_s | fifo_pop_s);
  assign ovf_set_s   = txdata_wr_s & fifo_full_s & ~fifo_pop_s;

  // DIV register and sticky overflow flag; a new overflow beats a clear
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      div_q <= DEFAULT_DIV;
      ovf_q <= 1'b0;
    end else begin
      if (div_wr_s) div_q <= HWDATA[15:0];
      if (ovf_set_s)                     ovf_q <= 1'b1;
      else if (status_wr_s && HWDATA[3]) ovf_q <= 1'b0;
    end
  end

  assign bit_done_s = (timer_q == div_lat_q - 16'd1);

  // Serialiser next state: START, 8 data bits LSB first, STOP, each div_lat cycles
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    div_lat_d  = div_lat_q;
    fifo_pop_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          shift_d    = fifo_rdata_s;
          div_lat_d  = eff_div(div_q);
          timer_d    = 16'd0;
          state_d    = S_START;
        end else begin
          timer_d = 16'd0;
        end
      end
      S_START: begin
        if (bit_done_s) begin
          timer_d   = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done_s) begin
          timer_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done_s) begin
          timer_d = 16'd0;
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            shift_d    = fifo_rdata_s;
            div_lat_d  = eff_div(div_q);
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = 16'd0;
      end
    endcase
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Serialiser state registers; reset aborts a frame and idles the line high
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      timer_q   <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      div_lat_q <= 16'd1;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      div_lat_q <= div_lat_d;
      tx_q      <= tx_d;
    end
  end

  mfp_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (fifo_push_s),
    .pop_i   (fifo_pop_s),
    .wdata_i (HWDATA[7:0]),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // STATUS word assembled from live state
  always_comb begin
    status_s                        = 32'd0;
    status_s[ST_BUSY_BIT]           = (state_q != S_IDLE);
    status_s[ST_FULL_BIT]           = fifo_full_s;
    status_s[ST_EMPTY_BIT]          = fifo_empty_s;
    status_s[ST_OVF_BIT]            = ovf_q;
    status_s[ST_CNT_MSB:ST_CNT_LSB] = fifo_count_s;
  end

  // Read mux driven from the latched data-phase address
  always_comb begin
    HRDATA = 32'd0;
    if (dsel_q && !dwr_q) begin
      case (daddr_q)
        REG_STATUS: HRDATA = status_s;
        REG_DIV:    HRDATA = {16'd0, div_q};
        default:    HRDATA = 32'd0;
      endcase
    end else begin
      HRDATA = 32'd0;
    end
  end

  assign HREADY  = 1'b1;
  assign UART_TX = tx_q;

endmodule
